// File: rtl/sd_sector_reader_if.sv
// Signal bundle between the CMD17 sector reader, its user side and the SD SPI mux.
// The reader takes the slave modport; whoever drives requests and the card line takes master.
interface sd_sector_reader_if;
    logic        sd_init_done;
    logic        rd_start_en;
    logic [31:0] rd_sec_addr;
    logic        sd_miso;
    logic        rd_sd_cs;
    logic        rd_sd_mosi;
    logic        rd_busy;
    logic        rd_en;
    logic [15:0] rd_data;
    logic        rd_err;

    modport slave (
        input  sd_init_done, rd_start_en, rd_sec_addr, sd_miso,
        output rd_sd_cs, rd_sd_mosi, rd_busy, rd_en, rd_data, rd_err
    );

    modport master (
        output sd_init_done, rd_start_en, rd_sec_addr, sd_miso,
        input  rd_sd_cs, rd_sd_mosi, rd_busy, rd_en, rd_data, rd_err
    );
endinterface

// File: rtl/sd_sector_reader.sv
// SPI-mode SD single-block read (CMD17): sends the command, checks R1, waits for the
// data token and streams the 512-byte sector out as 256 big-endian 16-bit words.
module sd_sector_reader #(
    parameter int         RESP_TIMEOUT  = 512,
    parameter int         TOKEN_TIMEOUT = 65536,
    parameter logic [7:0] CMD_CRC       = 8'hFF,
    parameter int         TAIL_CYCLES   = 8
) (
    input logic               clk_50m,
    input logic               reset,
    sd_sector_reader_if.slave bus
);
    localparam int RW = $clog2(RESP_TIMEOUT) + 1;
    localparam int TW = $clog2(TOKEN_TIMEOUT) + 1;
    localparam logic [RW-1:0] RESP_LAST  = RW'(RESP_TIMEOUT - 1);
    localparam logic [TW-1:0] TOKEN_LAST = TW'(TOKEN_TIMEOUT - 1);
    localparam logic [11:0]   TAIL_LAST  = 12'(TAIL_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE, SEND_CMD, WAIT_R1, RECV_R1, WAIT_TOKEN, RECV_DATA, RECV_CRC, TAIL
    } state_t;

    state_t        state_q, state_d;
    logic [11:0]   bit_cnt_q, bit_cnt_d;
    logic [RW-1:0] resp_cnt_q, resp_cnt_d;
    logic [TW-1:0] token_cnt_q, token_cnt_d;
    logic [47:0]   cmd_q, cmd_d;
    logic [14:0]   shift_q, shift_d;
    logic          cs_q, cs_d;
    logic          mosi_q, mosi_d;
    logic          busy_q, busy_d;
    logic          rd_en_q, rd_en_d;
    logic [15:0]   rd_data_q, rd_data_d;
    logic          err_q, err_d;
    logic          start_prev_q, start_prev_d;

    logic          start_edge;
    logic [15:0]   word_in;

    assign start_edge = bus.rd_start_en & ~start_prev_q;
    // Shift register plus the bit on MISO right now; low byte doubles as R1.
    assign word_in    = {shift_q, bus.sd_miso};

    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        resp_cnt_d   = resp_cnt_q;
        token_cnt_d  = token_cnt_q;
        cmd_d        = cmd_q;
        shift_d      = shift_q;
        cs_d         = cs_q;
        mosi_d       = mosi_q;
        busy_d       = busy_q;
        rd_en_d      = 1'b0;
        rd_data_d    = rd_data_q;
        err_d        = err_q;
        start_prev_d = bus.rd_start_en;

        case (state_q)
            IDLE: begin
                cs_d   = 1'b1;
                mosi_d = 1'b1;
                busy_d = 1'b0;
                if (start_edge && bus.sd_init_done) begin
                    state_d   = SEND_CMD;
                    cmd_d     = {8'h51, bus.rd_sec_addr, CMD_CRC};
                    bit_cnt_d = '0;
                    cs_d      = 1'b0;
                    mosi_d    = cmd_d[47];
                    busy_d    = 1'b1;
                    err_d     = 1'b0;
                end
            end

            SEND_CMD: begin
                if (bit_cnt_q == 12'd47) begin
                    state_d    = WAIT_R1;
                    mosi_d     = 1'b1;
                    resp_cnt_d = '0;
                end else begin
                    bit_cnt_d = bit_cnt_q + 12'd1;
                    cmd_d     = {cmd_q[46:0], 1'b1};
                    mosi_d    = cmd_q[46];
                end
            end

            WAIT_R1: begin
                if (!bus.sd_miso) begin
                    // This zero is R1 bit 7; seed the shifter with it.
                    state_d   = RECV_R1;
                    shift_d   = '0;
                    bit_cnt_d = '0;
                end else if (resp_cnt_q == RESP_LAST) begin
                    state_d   = TAIL;
                    err_d     = 1'b1;
                    cs_d      = 1'b1;
                    bit_cnt_d = '0;
                end else begin
                    resp_cnt_d = resp_cnt_q + RW'(1);
                end
            end

            RECV_R1: begin
                shift_d = word_in[14:0];
                if (bit_cnt_q == 12'd6) begin
                    if (word_in[7:0] != 8'h00) begin
                        state_d   = TAIL;
                        err_d     = 1'b1;
                        cs_d      = 1'b1;
                        bit_cnt_d = '0;
                    end else begin
                        state_d     = WAIT_TOKEN;
                        token_cnt_d = '0;
                    end
                end else begin
                    bit_cnt_d = bit_cnt_q + 12'd1;
                end
            end

            WAIT_TOKEN: begin
                if (!bus.sd_miso) begin
                    state_d   = RECV_DATA;
                    bit_cnt_d = '0;
                end else if (token_cnt_q == TOKEN_LAST) begin
                    state_d   = TAIL;
                    err_d     = 1'b1;
                    cs_d      = 1'b1;
                    bit_cnt_d = '0;
                end else begin
                    token_cnt_d = token_cnt_q + TW'(1);
                end
            end

            RECV_DATA: begin
                shift_d   = word_in[14:0];
                bit_cnt_d = bit_cnt_q + 12'd1;
                if (bit_cnt_q[3:0] == 4'hF) begin
                    rd_data_d = word_in;
                    rd_en_d   = 1'b1;
                end
                if (bit_cnt_q == 12'hFFF) begin
                    state_d   = RECV_CRC;
                    bit_cnt_d = '0;
                end
            end

            RECV_CRC: begin
                if (bit_cnt_q == 12'd15) begin
                    state_d   = TAIL;
                    cs_d      = 1'b1;
                    bit_cnt_d = '0;
                end else begin
                    bit_cnt_d = bit_cnt_q + 12'd1;
                end
            end

            TAIL: begin
                cs_d   = 1'b1;
                mosi_d = 1'b1;
                if (bit_cnt_q == TAIL_LAST) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end else begin
                    bit_cnt_d = bit_cnt_q + 12'd1;
                end
            end

            default: begin
                state_d = IDLE;
                cs_d    = 1'b1;
                mosi_d  = 1'b1;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_50m) begin
        if (reset) begin
            state_q      <= IDLE;
            bit_cnt_q    <= '0;
            resp_cnt_q   <= '0;
            token_cnt_q  <= '0;
            cmd_q        <= '0;
            shift_q      <= '0;
            cs_q         <= 1'b1;
            mosi_q       <= 1'b1;
            busy_q       <= 1'b0;
            rd_en_q      <= 1'b0;
            rd_data_q    <= '0;
            err_q        <= 1'b0;
            start_prev_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            resp_cnt_q   <= resp_cnt_d;
            token_cnt_q  <= token_cnt_d;
            cmd_q        <= cmd_d;
            shift_q      <= shift_d;
            cs_q         <= cs_d;
            mosi_q       <= mosi_d;
            busy_q       <= busy_d;
            rd_en_q      <= rd_en_d;
            rd_data_q    <= rd_data_d;
            err_q        <= err_d;
            start_prev_q <= start_prev_d;
        end
    end

    assign bus.rd_sd_cs   = cs_q;
    assign bus.rd_sd_mosi = mosi_q;
    assign bus.rd_busy    = busy_q;
    assign bus.rd_en      = rd_en_q;
    assign bus.rd_data    = rd_data_q;
    assign bus.rd_err     = err_q;
endmodule

// File: tb/tb_sd_sector_reader.sv
// Bench for sd_sector_reader: a bit-level SPI card model, a table of read scenarios
// and hand-written sequences for start gating and mid-transfer reset.
module tb_sd_sector_reader;
    localparam int RESP_TO = 512;
    localparam int TOK_TO  = 2048;
    localparam int TAIL    = 8;
    localparam int LIMIT   = 20000;

    logic clk_50m = 1'b0;
    logic reset   = 1'b1;
    int   cyc     = 0;

    sd_sector_reader_if rif ();

    sd_sector_reader #(
        .RESP_TIMEOUT (RESP_TO),
        .TOKEN_TIMEOUT(TOK_TO),
        .CMD_CRC      (8'hFF),
        .TAIL_CYCLES  (TAIL)
    ) dut (
        .clk_50m(clk_50m),
        .reset  (reset),
        .bus    (rif)
    );

    always #10 clk_50m = ~clk_50m;
    always @(posedge clk_50m) cyc <= cyc + 1;

    // ---------------- card model ----------------
    logic [7:0]  card_r1    = 8'h00;
    bit          card_resp  = 1'b1;
    bit          card_token = 1'b1;
    logic [7:0]  card_seed  = 8'h00;
    logic [47:0] card_sh    = '0;
    logic [47:0] card_last_cmd = '0;
    int          card_nbits = 0;
    bit          card_active = 1'b0;
    int          card_cmd_count = 0;
    int          card_cmd_cyc = 0;
    int          card_pop_cyc = 0;
    bit          card_q[$];

    function automatic logic [7:0] data_byte(input int k, input logic [7:0] seed);
        return 8'((k + int'(seed)) & 255);
    endfunction

    task automatic push_byte(input logic [7:0] v);
        for (int b = 7; b >= 0; b--) card_q.push_back(v[b]);
    endtask

    initial begin
        rif.sd_miso = 1'b1;
        forever begin
            @(negedge clk_50m);
            if (rif.rd_sd_cs === 1'b0 && !card_active) begin
                card_sh = {card_sh[46:0], rif.rd_sd_mosi};
                card_nbits++;
                if (card_nbits == 48) begin
                    card_active   = 1'b1;
                    card_last_cmd = card_sh;
                    card_cmd_count++;
                    card_cmd_cyc  = cyc;
                    card_q.delete();
                    if (card_resp) begin
                        for (int k = 0; k < 3; k++) push_byte(8'hFF);
                        push_byte(card_r1);
                        if (card_r1 == 8'h00 && card_token) begin
                            for (int k = 0; k < 10; k++) push_byte(8'hFF);
                            push_byte(8'hFE);
                            for (int k = 0; k < 512; k++) push_byte(data_byte(k, card_seed));
                            push_byte(8'h00);
                            push_byte(8'h00);
                        end
                    end
                end
            end
            @(posedge clk_50m);
            #1;
            if (rif.rd_sd_cs !== 1'b0) begin
                card_active = 1'b0;
                card_nbits  = 0;
                card_q.delete();
                rif.sd_miso = 1'b1;
            end else if (card_q.size() > 0) begin
                rif.sd_miso  = card_q.pop_front();
                card_pop_cyc = cyc;
            end else begin
                rif.sd_miso = 1'b1;
            end
        end
    end

    // ---------------- checking ----------------
    int total = 0;
    int bad   = 0;
    logic [15:0] exp_q[$];
    int strobes = 0;
    int last_strobe_cyc = -1;
    int cs_rise_cyc = -1;
    int busy_fall_cyc = -1;
    logic prev_cs = 1'b1;
    logic prev_busy = 1'b0;

    task automatic chk(input string name, input longint got, input longint want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d", name, got, want);
        end
    endtask

    task automatic chk_h(input string name, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h", name, got, want);
        end
    endtask

    task automatic chk_rng(input string name, input longint got, input longint lo, input longint hi);
        total++;
        if (got < lo || got > hi) begin
            bad++;
            $display("FAIL %s got=%0d want=[%0d..%0d]", name, got, lo, hi);
        end
    endtask

    // One clock of observation, sampled on the falling edge.
    task automatic tick();
        logic [15:0] w;
        @(negedge clk_50m);
        if (rif.rd_en === 1'b1) begin
            strobes++;
            if (last_strobe_cyc >= 0)
                chk_rng("strobe_gap", longint'(cyc - last_strobe_cyc), 16, 64'd1000000000);
            last_strobe_cyc = cyc;
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_rd_en got=%h want=no_strobe", rif.rd_data);
            end else begin
                w = exp_q.pop_front();
                chk_h("rd_data", 64'(rif.rd_data), 64'(w));
            end
        end
        if (prev_cs === 1'b0 && rif.rd_sd_cs === 1'b1) cs_rise_cyc = cyc;
        if (prev_busy === 1'b1 && rif.rd_busy === 1'b0) busy_fall_cyc = cyc;
        prev_cs   = rif.rd_sd_cs;
        prev_busy = rif.rd_busy;
    endtask

    task automatic push_sector(input logic [7:0] seed);
        for (int i = 0; i < 256; i++)
            exp_q.push_back({data_byte(2 * i, seed), data_byte(2 * i + 1, seed)});
    endtask

    task automatic pulse_start(input logic [31:0] addr);
        rif.rd_sec_addr = addr;
        rif.rd_start_en = 1'b1;
        tick();
        rif.rd_start_en = 1'b0;
        rif.rd_sec_addr = ~addr;
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (rif.rd_busy === 1'b1 && n < LIMIT) begin
            tick();
            n++;
        end
        chk("busy_bounded", longint'(n < LIMIT), 1);
    endtask

    typedef struct {
        string       name;
        logic [31:0] addr;
        logic [7:0]  r1;
        bit          resp;
        bit          token;
        logic [7:0]  seed;
        int          exp_words;
        logic        exp_err;
        bit          ref_cmd;   // cs delta measured from end of command, else from last card bit
        int          cs_lo;
        int          cs_hi;
    } vec_t;

    function automatic vec_t mk(input string name, input logic [31:0] addr, input logic [7:0] r1,
                                input bit resp, input bit token, input logic [7:0] seed,
                                input int words, input logic err, input bit ref_cmd,
                                input int lo, input int hi);
        vec_t v;
        v.name = name; v.addr = addr; v.r1 = r1; v.resp = resp; v.token = token;
        v.seed = seed; v.exp_words = words; v.exp_err = err; v.ref_cmd = ref_cmd;
        v.cs_lo = lo; v.cs_hi = hi;
        return v;
    endfunction

    task automatic run_vec(input vec_t v);
        int s0, c0, n;
        longint refc;
        card_r1 = v.r1; card_resp = v.resp; card_token = v.token; card_seed = v.seed;
        if (v.resp && v.r1 == 8'h00 && v.token) push_sector(v.seed);
        s0 = strobes;
        c0 = card_cmd_count;
        cs_rise_cyc = -1;
        busy_fall_cyc = -1;
        pulse_start(v.addr);
        chk({v.name, "_busy_rise"}, longint'(rif.rd_busy), 1);
        chk({v.name, "_err_clear"}, longint'(rif.rd_err), 0);
        wait_idle(n);
        chk({v.name, "_cmd_count"}, longint'(card_cmd_count - c0), 1);
        chk_h({v.name, "_cmd"}, 64'(card_last_cmd), 64'({8'h51, v.addr, 8'hFF}));
        chk({v.name, "_strobes"}, longint'(strobes - s0), longint'(v.exp_words));
        chk({v.name, "_err"}, longint'(rif.rd_err), longint'(v.exp_err));
        chk({v.name, "_words_left"}, longint'(exp_q.size()), 0);
        refc = v.ref_cmd ? longint'(card_cmd_cyc) : longint'(card_pop_cyc);
        chk_rng({v.name, "_cs_delta"}, longint'(cs_rise_cyc) - refc, v.cs_lo, v.cs_hi);
        chk({v.name, "_tail_len"}, longint'(busy_fall_cyc - cs_rise_cyc), TAIL);
        chk({v.name, "_idle_mosi"}, longint'(rif.rd_sd_mosi), 1);
        $display("txn %s addr=%h words=%0d err=%0b cycles=%0d", v.name, v.addr,
                 strobes - s0, rif.rd_err, n);
        exp_q.delete();
        repeat (4) tick();
    endtask

    vec_t vecs[7];

    initial begin
        int s0, c0, n, s1;
        bit any_busy, any_cs_low;

        vecs[0] = mk("normal",      32'h0000_1234, 8'h00, 1, 1, 8'h00, 256, 1'b0, 0, 1, 1);
        vecs[1] = mk("r1_05",       32'hDEAD_BEEF, 8'h05, 1, 1, 8'h00, 0,   1'b1, 0, 1, 1);
        vecs[2] = mk("resp_tmo",    32'h0000_0000, 8'h00, 0, 1, 8'h00, 0,   1'b1, 1, RESP_TO, RESP_TO + 2);
        vecs[3] = mk("after_err",   32'hFFFF_FFFF, 8'h00, 1, 1, 8'h37, 256, 1'b0, 0, 1, 1);
        vecs[4] = mk("token_tmo",   32'h0102_0304, 8'h00, 1, 0, 8'h00, 0,   1'b1, 0, TOK_TO, TOK_TO + 2);
        vecs[5] = mk("r1_01",       32'h0BAD_F00D, 8'h01, 1, 1, 8'h00, 0,   1'b1, 0, 1, 1);
        vecs[6] = mk("normal_hi",   32'h8000_0001, 8'h00, 1, 1, 8'hC3, 256, 1'b0, 0, 1, 1);

        rif.sd_init_done = 1'b0;
        rif.rd_start_en  = 1'b0;
        rif.rd_sec_addr  = '0;
        repeat (5) tick();
        chk("rst_cs",   longint'(rif.rd_sd_cs), 1);
        chk("rst_mosi", longint'(rif.rd_sd_mosi), 1);
        chk("rst_busy", longint'(rif.rd_busy), 0);
        chk("rst_en",   longint'(rif.rd_en), 0);
        chk_h("rst_data", 64'(rif.rd_data), 64'h0);
        chk("rst_err",  longint'(rif.rd_err), 0);
        reset = 1'b0;
        repeat (3) tick();

        // Start while the card is not initialised: dropped, and not replayed later.
        c0 = card_cmd_count;
        any_busy = 1'b0;
        any_cs_low = 1'b0;
        pulse_start(32'h0000_0042);
        for (int i = 0; i < 100; i++) begin
            if (i == 50) rif.sd_init_done = 1'b1;
            tick();
            any_busy   |= (rif.rd_busy === 1'b1);
            any_cs_low |= (rif.rd_sd_cs !== 1'b1);
        end
        chk("noinit_busy", longint'(any_busy), 0);
        chk("noinit_cs", longint'(any_cs_low), 0);
        chk("noinit_cmds", longint'(card_cmd_count - c0), 0);
        $display("txn no_init cmds=%0d", card_cmd_count - c0);

        for (int i = 0; i < 7; i++) run_vec(vecs[i]);

        // Second start mid-transfer, plus init dropping: one transfer, completed normally.
        card_r1 = 8'h00; card_resp = 1'b1; card_token = 1'b1; card_seed = 8'h11;
        push_sector(8'h11);
        s0 = strobes;
        c0 = card_cmd_count;
        pulse_start(32'h00AB_CDEF);
        repeat (200) tick();
        pulse_start(32'h5555_AAAA);
        rif.sd_init_done = 1'b0;
        wait_idle(n);
        repeat (300) tick();
        chk("busy_pulse_cmds", longint'(card_cmd_count - c0), 1);
        chk_h("busy_pulse_cmd", 64'(card_last_cmd), 64'({8'h51, 32'h00AB_CDEF, 8'hFF}));
        chk("busy_pulse_strobes", longint'(strobes - s0), 256);
        chk("busy_pulse_err", longint'(rif.rd_err), 0);
        chk("busy_pulse_idle", longint'(rif.rd_busy), 0);
        $display("txn busy_pulse words=%0d cmds=%0d", strobes - s0, card_cmd_count - c0);
        exp_q.delete();
        rif.sd_init_done = 1'b1;
        repeat (4) tick();

        // Level held high for 10000 cycles starts exactly one transfer.
        card_seed = 8'h5A;
        push_sector(8'h5A);
        s0 = strobes;
        c0 = card_cmd_count;
        rif.rd_sec_addr = 32'h0000_7777;
        rif.rd_start_en = 1'b1;
        repeat (10000) tick();
        chk("held_cmds", longint'(card_cmd_count - c0), 1);
        chk("held_strobes", longint'(strobes - s0), 256);
        chk("held_idle", longint'(rif.rd_busy), 0);
        chk("held_err", longint'(rif.rd_err), 0);
        $display("txn held_start words=%0d cmds=%0d", strobes - s0, card_cmd_count - c0);
        rif.rd_start_en = 1'b0;
        exp_q.delete();
        repeat (4) tick();

        // Reset after 100 words: outputs to reset values next cycle, no stray strobe.
        card_seed = 8'h80;
        push_sector(8'h80);
        s0 = strobes;
        pulse_start(32'h0000_0100);
        n = 0;
        while ((strobes - s0) < 100 && n < LIMIT) begin
            tick();
            n++;
        end
        chk("rst_mid_reached", longint'(strobes - s0), 100);
        reset = 1'b1;
        tick();
        chk("rst_mid_cs",   longint'(rif.rd_sd_cs), 1);
        chk("rst_mid_mosi", longint'(rif.rd_sd_mosi), 1);
        chk("rst_mid_busy", longint'(rif.rd_busy), 0);
        chk("rst_mid_en",   longint'(rif.rd_en), 0);
        chk_h("rst_mid_data", 64'(rif.rd_data), 64'h0);
        exp_q.delete();
        reset = 1'b0;
        s1 = strobes;
        repeat (50) tick();
        chk("rst_mid_quiet", longint'(strobes - s1), 0);
        $display("txn reset_mid words_before=%0d", s1 - s0);
        run_vec(mk("post_reset", 32'h0000_2000, 8'h00, 1, 1, 8'h09, 256, 1'b0, 0, 1, 1));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
